// File: rtl/memory_game_controller.sv
// Game-logic core for the pairs memory game: cursor, pick/compare/hide FSM,
// face-up and removed masks, move counter and win detection.
module memory_game_controller #(
    parameter int unsigned GRID_SIZE_X     = 5,
    parameter int unsigned GRID_SIZE_Y     = 4,
    parameter int unsigned PAIR_ID_W       = 4,
    parameter int unsigned MISMATCH_FRAMES = 60,
    parameter bit          WRAP_CURSOR     = 1'b0,
    localparam int unsigned N  = GRID_SIZE_X * GRID_SIZE_Y,
    localparam int unsigned XW = $clog2(GRID_SIZE_X),
    localparam int unsigned YW = (GRID_SIZE_Y > 1) ? $clog2(GRID_SIZE_Y) : 1
) (
    input  logic                   clock_25M,
    input  logic                   reset,
    input  logic                   frame,
    input  logic                   right,
    input  logic                   left,
    input  logic                   up,
    input  logic                   down,
    input  logic                   select,
    input  logic [N*PAIR_ID_W-1:0] layout,
    output logic [XW-1:0]          cursor_x,
    output logic [YW-1:0]          cursor_y,
    output logic [N-1:0]           flipped,
    output logic [N-1:0]           removed,
    output logic [15:0]            moves,
    output logic                   game_over
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = $clog2(N / 2 + 1);
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        S_PICK1,
        S_PICK2,
        S_CHECK,
        S_SHOW,
        S_WIN
    } state_t;

    state_t          r_state;
    logic [XW-1:0]   r_cursor_x;
    logic [YW-1:0]   r_cursor_y;
    logic [N-1:0]    r_flipped;
    logic [N-1:0]    r_removed;
    logic [15:0]     r_moves;
    logic            r_game_over;
    logic [CW-1:0]   r_first;
    logic [CW-1:0]   r_second;
    logic [PW-1:0]   r_pairs_left;
    logic [TW-1:0]   r_timer;
    logic [4:0]      r_prev;

    logic [4:0]      w_btn;
    logic [4:0]      w_press;
    logic            w_pr_right;
    logic            w_pr_left;
    logic            w_pr_up;
    logic            w_pr_down;
    logic            w_pr_sel;
    logic [CW-1:0]   w_cell;
    logic            w_cell_free;
    logic            w_ids_equal;
    logic [XW-1:0]   w_next_x;
    logic [YW-1:0]   w_next_y;

    // Rising-edge detection between consecutive frame samples
    assign w_btn      = {select, down, up, left, right};
    assign w_press    = frame ? (w_btn & ~r_prev) : 5'b0;
    assign w_pr_right = w_press[0];
    assign w_pr_left  = w_press[1];
    assign w_pr_up    = w_press[2];
    assign w_pr_down  = w_press[3];
    assign w_pr_sel   = w_press[4];

    assign w_cell      = CW'(32'(r_cursor_y) * GRID_SIZE_X + 32'(r_cursor_x));
    assign w_cell_free = !r_flipped[w_cell] && !r_removed[w_cell];
    assign w_ids_equal = layout[32'(r_first) * PAIR_ID_W +: PAIR_ID_W]
                      == layout[32'(r_second) * PAIR_ID_W +: PAIR_ID_W];

    // Next cursor position; edges use explicit compares, never overflow
    always_comb begin
        w_next_x = r_cursor_x;
        w_next_y = r_cursor_y;
        if (w_pr_right && !w_pr_left) begin
            if (r_cursor_x == XW'(GRID_SIZE_X - 1))
                w_next_x = WRAP_CURSOR ? '0 : r_cursor_x;
            else
                w_next_x = r_cursor_x + XW'(1);
        end else if (w_pr_left && !w_pr_right) begin
            if (r_cursor_x == '0)
                w_next_x = WRAP_CURSOR ? XW'(GRID_SIZE_X - 1) : r_cursor_x;
            else
                w_next_x = r_cursor_x - XW'(1);
        end
        if (w_pr_down && !w_pr_up) begin
            if (r_cursor_y == YW'(GRID_SIZE_Y - 1))
                w_next_y = WRAP_CURSOR ? '0 : r_cursor_y;
            else
                w_next_y = r_cursor_y + YW'(1);
        end else if (w_pr_up && !w_pr_down) begin
            if (r_cursor_y == '0)
                w_next_y = WRAP_CURSOR ? YW'(GRID_SIZE_Y - 1) : r_cursor_y;
            else
                w_next_y = r_cursor_y - YW'(1);
        end
    end

    always_ff @(posedge clock_25M or posedge reset) begin
        if (reset) begin
            r_state      <= S_PICK1;
            r_cursor_x   <= '0;
            r_cursor_y   <= '0;
            r_flipped    <= '0;
            r_removed    <= '0;
            r_moves      <= '0;
            r_game_over  <= 1'b0;
            r_first      <= '0;
            r_second     <= '0;
            r_pairs_left <= PW'(N / 2);
            r_timer      <= '0;
            r_prev       <= '1;
        end else begin
            if (frame)
                r_prev <= w_btn;
            if (r_state != S_WIN) begin
                r_cursor_x <= w_next_x;
                r_cursor_y <= w_next_y;
            end
            case (r_state)
                S_PICK1: begin
                    if (w_pr_sel && w_cell_free) begin
                        r_flipped[w_cell] <= 1'b1;
                        r_first           <= w_cell;
                        r_state           <= S_PICK2;
                    end
                end
                S_PICK2: begin
                    if (w_pr_sel && w_cell_free && (w_cell != r_first)) begin
                        r_flipped[w_cell] <= 1'b1;
                        r_second          <= w_cell;
                        if (r_moves != 16'hFFFF)
                            r_moves <= r_moves + 16'd1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_ids_equal) begin
                        r_removed[r_first]  <= 1'b1;
                        r_removed[r_second] <= 1'b1;
                        r_flipped[r_first]  <= 1'b0;
                        r_flipped[r_second] <= 1'b0;
                        r_pairs_left        <= r_pairs_left - PW'(1);
                        if (r_pairs_left == PW'(1)) begin
                            r_game_over <= 1'b1;
                            r_state     <= S_WIN;
                        end else begin
                            r_state <= S_PICK1;
                        end
                    end else begin
                        r_timer <= TW'(MISMATCH_FRAMES);
                        r_state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (frame) begin
                        if (r_timer == TW'(1)) begin
                            r_flipped[r_first]  <= 1'b0;
                            r_flipped[r_second] <= 1'b0;
                            r_state             <= S_PICK1;
                        end
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_WIN: begin
                    if (w_pr_sel) begin
                        r_flipped    <= '0;
                        r_removed    <= '0;
                        r_moves      <= '0;
                        r_cursor_x   <= '0;
                        r_cursor_y   <= '0;
                        r_pairs_left <= PW'(N / 2);
                        r_game_over  <= 1'b0;
                        r_state      <= S_PICK1;
                    end
                end
                default: r_state <= S_PICK1;
            endcase
        end
    end

    assign cursor_x  = r_cursor_x;
    assign cursor_y  = r_cursor_y;
    assign flipped   = r_flipped;
    assign removed   = r_removed;
    assign moves     = r_moves;
    assign game_over = r_game_over;

endmodule

// File: tb/tb_memory_game_controller.sv
// Directed scoreboard bench for memory_game_controller: cursor edges, match,
// mismatch timing, ignored picks, win/restart and reset behaviour.
module tb_memory_game_controller;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_R    = 5'b00001;
    localparam logic [4:0] B_L    = 5'b00010;
    localparam logic [4:0] B_U    = 5'b00100;
    localparam logic [4:0] B_D    = 5'b01000;
    localparam logic [4:0] B_S    = 5'b10000;

    logic        clk;
    logic        frame;
    logic        b_right, b_left, b_up, b_down, b_select;
    logic        rst0, rst1, rst2;
    logic [79:0] lay0;
    logic [3:0]  lay2;

    logic [2:0]  cx0, cx1;
    logic [1:0]  cy0, cy1;
    logic [19:0] fl0, rm0, fl1, rm1;
    logic [15:0] mv0, mv1, mv2;
    logic        go0, go1, go2;
    logic        cx2, cy2;
    logic [3:0]  fl2, rm2;

    int unsigned errors = 0;
    int unsigned checks = 0;
    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    memory_game_controller #(
        .GRID_SIZE_X(5), .GRID_SIZE_Y(4), .PAIR_ID_W(4),
        .MISMATCH_FRAMES(3), .WRAP_CURSOR(1'b0)
    ) u_dut0 (
        .clock_25M(clk), .reset(rst0), .frame(frame),
        .right(b_right), .left(b_left), .up(b_up), .down(b_down), .select(b_select),
        .layout(lay0), .cursor_x(cx0), .cursor_y(cy0), .flipped(fl0),
        .removed(rm0), .moves(mv0), .game_over(go0)
    );

    memory_game_controller #(
        .GRID_SIZE_X(5), .GRID_SIZE_Y(4), .PAIR_ID_W(4),
        .MISMATCH_FRAMES(3), .WRAP_CURSOR(1'b1)
    ) u_dut1 (
        .clock_25M(clk), .reset(rst1), .frame(frame),
        .right(b_right), .left(b_left), .up(b_up), .down(b_down), .select(b_select),
        .layout(lay0), .cursor_x(cx1), .cursor_y(cy1), .flipped(fl1),
        .removed(rm1), .moves(mv1), .game_over(go1)
    );

    memory_game_controller #(
        .GRID_SIZE_X(2), .GRID_SIZE_Y(2), .PAIR_ID_W(1),
        .MISMATCH_FRAMES(60), .WRAP_CURSOR(1'b0)
    ) u_dut2 (
        .clock_25M(clk), .reset(rst2), .frame(frame),
        .right(b_right), .left(b_left), .up(b_up), .down(b_down), .select(b_select),
        .layout(lay2), .cursor_x(cx2), .cursor_y(cy2), .flipped(fl2),
        .removed(rm2), .moves(mv2), .game_over(go2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 5x4 layouts: cells 0/1 share id 3, or cells 0/1 hold ids 2/5 (mismatch)
    function automatic logic [79:0] make_layout(input bit mismatch);
        logic [79:0] l;
        int          id;
        int          k;
        l = '0;
        for (int c = 0; c < 20; c++) begin
            if (!mismatch) begin
                k  = (c - 2) / 2;
                id = (c < 2) ? 3 : ((k < 3) ? k : k + 1);
            end else if (c < 4) begin
                id = (c % 2 == 0) ? 2 : 5;
            end else begin
                k  = (c - 4) / 2;
                id = (k < 2) ? k : ((k < 4) ? k + 1 : k + 2);
            end
            l[c*4 +: 4] = 4'(id);
        end
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // One frame pulse with the given button levels; buttons stay driven after
    task automatic fr(input logic [4:0] b);
        {b_select, b_down, b_up, b_left, b_right} = b;
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic release_btns();
        fr(B_NONE);
        tick();
        tick();
    endtask

    task automatic tap(input logic [4:0] b);
        fr(b);
        tick();
        release_btns();
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        checks++;
        if (sb_exp.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            tag   = sb_tag.pop_front();
            exp_v = sb_exp.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
            end
        end
    endtask

    initial begin
        int ex0[6];
        int ex1[6];
        ex0 = '{1, 2, 3, 4, 4, 4};
        ex1 = '{1, 2, 3, 4, 0, 1};
        frame = 1'b0;
        {b_select, b_down, b_up, b_left, b_right} = B_NONE;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        lay0 = make_layout(1'b0);
        lay2 = 4'b1010;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset state
        expect_v("rst_x", 0);   check_v(32'(cx0));
        expect_v("rst_y", 0);   check_v(32'(cy0));
        expect_v("rst_fl", 0);  check_v(32'(fl0));
        expect_v("rst_rm", 0);  check_v(32'(rm0));
        expect_v("rst_mv", 0);  check_v(32'(mv0));
        expect_v("rst_go", 0);  check_v(32'(go0));
        expect_v("rst1_fl", 0); check_v(32'(fl1));
        expect_v("rst1_rm", 0); check_v(32'(rm1));
        expect_v("rst1_mv", 0); check_v(32'(mv1));
        expect_v("rst1_go", 0); check_v(32'(go1));
        release_btns();

        // Cursor saturation (dut0) versus wrap (dut1)
        for (int i = 0; i < 6; i++) begin
            expect_v($sformatf("right%0d_sat", i), 32'(ex0[i]));
            expect_v($sformatf("right%0d_wrap", i), 32'(ex1[i]));
            fr(B_R);
            check_v(32'(cx0));
            check_v(32'(cx1));
            release_btns();
        end
        expect_v("up_sat", 0);  expect_v("up_wrap", 3);
        fr(B_U); check_v(32'(cy0)); check_v(32'(cy1)); release_btns();
        expect_v("down_sat", 1); expect_v("down_wrap", 0);
        fr(B_D); check_v(32'(cy0)); check_v(32'(cy1)); release_btns();

        // Match on cells 0 and 1
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        release_btns();
        expect_v("pick1_fl", 32'h1);
        fr(B_S); check_v(32'(fl0)); release_btns();
        expect_v("move_x1", 1);
        fr(B_R); check_v(32'(cx0)); release_btns();
        expect_v("pick2_fl", 32'h3); expect_v("pick2_mv", 1);
        fr(B_S); check_v(32'(fl0)); check_v(32'(mv0));
        tick();
        expect_v("match_rm", 32'h3); expect_v("match_fl", 0);
        expect_v("match_mv", 1);     expect_v("match_go", 0);
        check_v(32'(rm0)); check_v(32'(fl0)); check_v(32'(mv0)); check_v(32'(go0));
        release_btns();

        // Ignored picks: removed cell, same cell twice, left+right together
        expect_v("sel_removed_fl", 0); expect_v("sel_removed_mv", 1);
        fr(B_S); check_v(32'(fl0)); check_v(32'(mv0)); release_btns();
        tap(B_R);
        expect_v("pick_c2_fl", 32'h4);
        fr(B_S); check_v(32'(fl0)); release_btns();
        expect_v("same_cell_fl", 32'h4); expect_v("same_cell_mv", 1);
        fr(B_S); tick(); check_v(32'(fl0)); check_v(32'(mv0)); release_btns();
        expect_v("lr_x", 2); expect_v("lr_fl", 32'h4);
        fr(B_L | B_R); check_v(32'(cx0)); check_v(32'(fl0)); release_btns();

        // Reset while a pick is pending
        rst0 = 1'b1; tick();
        expect_v("midrst_fl", 0); expect_v("midrst_x", 0); expect_v("midrst_mv", 0);
        check_v(32'(fl0)); check_v(32'(cx0)); check_v(32'(mv0));
        lay0 = make_layout(1'b1);
        rst0 = 1'b0;
        release_btns();

        // Mismatch, 3-frame display, select ignored during SHOW
        tap(B_S);
        tap(B_R);
        expect_v("mm_pick2_fl", 32'h3); expect_v("mm_pick2_mv", 1);
        fr(B_S); check_v(32'(fl0)); check_v(32'(mv0));
        tick();
        expect_v("mm_show_fl", 32'h3); expect_v("mm_show_rm", 0);
        check_v(32'(fl0)); check_v(32'(rm0));
        release_btns();
        expect_v("mm_frame1_fl", 32'h3); check_v(32'(fl0));
        expect_v("mm_frame2_fl", 32'h3); expect_v("mm_show_sel_mv", 1);
        fr(B_S); check_v(32'(fl0)); check_v(32'(mv0));
        release_btns();
        expect_v("mm_frame3_fl", 0); expect_v("mm_frame3_mv", 1);
        check_v(32'(fl0)); check_v(32'(mv0));

        // Second mismatch, then reset during SHOW with buttons held
        tap(B_S);
        tap(B_L);
        expect_v("mm2_fl", 32'h3); expect_v("mm2_mv", 2);
        fr(B_S); check_v(32'(fl0)); check_v(32'(mv0));
        tick(); release_btns();
        expect_v("show_cursor_x", 1);
        fr(B_R); check_v(32'(cx0));
        b_select = 1'b1;
        rst0 = 1'b1; tick();
        expect_v("showrst_x", 0);  expect_v("showrst_y", 0);
        expect_v("showrst_fl", 0); expect_v("showrst_rm", 0);
        expect_v("showrst_mv", 0); expect_v("showrst_go", 0);
        check_v(32'(cx0)); check_v(32'(cy0)); check_v(32'(fl0));
        check_v(32'(rm0)); check_v(32'(mv0)); check_v(32'(go0));
        rst0 = 1'b0; tick();
        expect_v("held_fl", 0); expect_v("held_x", 0);
        fr(B_S | B_R); check_v(32'(fl0)); check_v(32'(cx0));
        tick();
        expect_v("held2_fl", 0);
        fr(B_S | B_R); check_v(32'(fl0));
        release_btns();
        expect_v("after_release_fl", 32'h1);
        fr(B_S); check_v(32'(fl0)); release_btns();

        // 2x2 game: solve, win, frozen cursor, restart
        rst2 = 1'b0; tick();
        expect_v("g2_rst_go", 0); check_v(32'(go2));
        release_btns();
        tap(B_S);
        expect_v("g2_down_y", 1);
        fr(B_D); check_v(32'(cy2)); release_btns();
        expect_v("g2_p1_fl", 32'h5); expect_v("g2_p1_mv", 1);
        fr(B_S); check_v(32'(fl2)); check_v(32'(mv2));
        tick();
        expect_v("g2_m1_rm", 32'h5); expect_v("g2_m1_fl", 0); expect_v("g2_m1_go", 0);
        check_v(32'(rm2)); check_v(32'(fl2)); check_v(32'(go2));
        release_btns();
        tap(B_U);
        tap(B_R);
        tap(B_S);
        tap(B_D);
        expect_v("g2_p2_mv", 2);
        fr(B_S); check_v(32'(mv2));
        expect_v("g2_go_early", 0); check_v(32'(go2));
        tick();
        expect_v("g2_win_go", 1); expect_v("g2_win_rm", 32'hF); expect_v("g2_win_fl", 0);
        check_v(32'(go2)); check_v(32'(rm2)); check_v(32'(fl2));
        release_btns();
        expect_v("g2_frozen_x", 1); expect_v("g2_frozen_y", 1); expect_v("g2_frozen_go", 1);
        fr(B_L | B_U); check_v(32'(cx2)); check_v(32'(cy2)); check_v(32'(go2));
        release_btns();
        expect_v("g2_rs_go", 0); expect_v("g2_rs_fl", 0); expect_v("g2_rs_rm", 0);
        expect_v("g2_rs_mv", 0); expect_v("g2_rs_x", 0);  expect_v("g2_rs_y", 0);
        fr(B_S);
        check_v(32'(go2)); check_v(32'(fl2)); check_v(32'(rm2));
        check_v(32'(mv2)); check_v(32'(cx2)); check_v(32'(cy2));
        release_btns();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_game_controller.md
# memory_game_controller

Parametrised game-logic core for the VGA memory (pairs) game. It owns the grid cursor, the pick-two/compare/hide state machine, per-cell face-up and removed masks, a move counter and win detection. The grid size, mismatch display time and cursor wrap mode are configurable. It runs in the `clock_25M` domain between the button debouncers and the pixel painter, and advances only on `frame` pulses.

## Interface
- `GRID_SIZE_X`, 5: grid columns, at least 2.
- `GRID_SIZE_Y`, 4: grid rows, at least 1. `N = GRID_SIZE_X*GRID_SIZE_Y` must be even.
- `PAIR_ID_W`, 4: width of one pair id. Must satisfy `2**PAIR_ID_W >= N/2`.
- `MISMATCH_FRAMES`, 60: number of frames a mismatched pair stays face-up. Must be 1 to 255.
- `WRAP_CURSOR`, 0: 1 makes the cursor wrap at grid edges; 0 makes it saturate.
- `clock_25M` in 1: the only clock.
- `reset` in 1: asynchronous, active-high.
- `frame` in 1: one-cycle pulse per video frame.
- `right`, `left`, `up`, `down`, `select` in 1 each: debounced button levels.
- `layout` in N*PAIR_ID_W: pair id of cell `c = y*GRID_SIZE_X + x`, stored at bits `[c*PAIR_ID_W +: PAIR_ID_W]`. Each id appears exactly twice. The driver holds it stable except during reset.
- `cursor_x` out clog2(GRID_SIZE_X): cursor column.
- `cursor_y` out max(1,clog2(GRID_SIZE_Y)): cursor row.
- `flipped` out N: face-up mask.
- `removed` out N: mask of matched cells.
- `moves` out 16: completed pick pairs, saturates at 65535.
- `game_over` out 1: high in WIN.

## Operation
- Buttons are sampled only on `frame` cycles. A press is the current sample high while the previous frame's sample was low. Previous-sample registers reset to 1, so a button held through reset does nothing until it is released.
- Cursor, evaluated every state except WIN:
  - `right` increments x. At `GRID_SIZE_X-1` it wraps to 0 if `WRAP_CURSOR`, otherwise it holds.
  - `left` decrements x. At 0 it wraps to `GRID_SIZE_X-1` if `WRAP_CURSOR`, otherwise it holds.
  - `up` decrements y and `down` increments y, with the same edge rules.
  - `right` and `left` pressed together: x unchanged. `up` and `down` together: y unchanged. X and Y move independently in the same frame.
- Selected cell `c` is the cursor position before any move in that same frame.
- States: PICK1, PICK2, CHECK, SHOW, WIN. A 1-bit `wrap` on an edge may not be implemented via out-of-range arithmetic; use explicit compares.
  - PICK1: on a `select` press at a cell that is neither flipped nor removed, set `flipped[c]`, store `first=c`, go to PICK2. A press at any other cell is ignored.
  - PICK2: on a `select` press at a cell that is not `first`, not removed and not flipped, set `flipped[c]`, store `second=c`, increment `moves` (saturating), go to CHECK. An invalid press is ignored.
  - CHECK lasts exactly one cycle.
    - Equal ids: set `removed` for both cells, clear their `flipped` bits, decrement `pairs_left`. If `pairs_left` reaches 0, go to WIN; otherwise go to PICK1.
    - Unequal ids: load `timer = MISMATCH_FRAMES`, go to SHOW.
  - SHOW: each `frame` pulse decrements `timer`. On the frame where `timer` is 1, clear both `flipped` bits and go to PICK1. `select` is ignored; the cursor still moves.
  - WIN: `game_over=1`; the cursor is frozen. A `select` press clears `flipped`, `removed` and `moves`, sets the cursor to (0,0) and `pairs_left=N/2`, and goes to PICK1.
- Reset values: cursor (0,0), `flipped=0`, `removed=0`, `moves=0`, `game_over=0`, state PICK1, `pairs_left=N/2`, `timer=0`.

## Timing
- All outputs are registered.
- Cursor and `flipped` updates are visible the cycle after the `frame` cycle that caused them.
- CHECK occupies the cycle after the second pick. `removed` (match) or the SHOW entry (mismatch) is visible 2 cycles after the `frame` of the second pick.
- A mismatch remains face-up for exactly `MISMATCH_FRAMES` frame pulses counted after CHECK.
- `game_over` rises 2 cycles after the final matching pick's `frame`.
- Asserting reset mid-operation, including in SHOW or CHECK, immediately forces all reset values with no partial update.

## Test plan
- 5x4, `WRAP_CURSOR=0`: reset, then 6 `right` presses on separate frames: `cursor_x` goes 1,2,3,4,4,4. Then `up` at y=0 keeps y=0, and `down` gives y=1. Repeat with `WRAP_CURSOR=1`: the fifth press gives x=0, and `up` at y=0 gives y=3.
- Match: cells 0 and 1 have id 3. Select at (0,0), press `right`, then select. `flipped=...011` after the second pick; 2 cycles after that frame, `removed=...011`, `flipped=0` and `moves=1`.
- Mismatch with `MISMATCH_FRAMES=3`: cells 0 and 1 have ids 2 and 5. After CHECK, `flipped` stays 0b11 for 2 frames and clears on the 3rd. A `select` press during SHOW is ignored and `moves` stays 1.
- Ignored picks: selecting the same cell twice, a removed cell, or pressing `left` and `right` together all leave `flipped`, `moves` and the cursor unchanged.
- 2x2, ids {0,1,0,1}: solve in 2 moves, giving `game_over=1` and `moves=2`. A `select` press then restarts the game with all masks 0, the cursor at (0,0) and `game_over=0`.
- Assert reset during SHOW: all outputs read their reset values on the next cycle. A button held across reset release produces no action until it is released and pressed again.
